// File: rtl/ysyx_24080006_pkg.sv
// Shared types and sizes for the writeback stage: register address width,
// result-source encoding and the request record used by the arbiter mux.
package ysyx_24080006_pkg;

  localparam int REG_WIDTH  = 5;
  localparam int NUM_REGS   = 1 << REG_WIDTH;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_LSU,
    WB_MDU,
    WB_ALU
  } wb_src_e;

  typedef struct packed {
    logic                  valid;
    logic [REG_WIDTH-1:0]  rd;
    logic [DATA_WIDTH-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/ysyx_24080006_scoreboard.sv
// Per-register busy scoreboard: set on issue, cleared by the register-file write
// port, and the decode stall check that honours write-through forwarding.
module ysyx_24080006_scoreboard
  import ysyx_24080006_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 issue_valid,
  input  logic [REG_WIDTH-1:0] issue_rd,
  input  logic                 reg_we,
  input  logic [REG_WIDTH-1:0] rd_addr,
  input  logic [REG_WIDTH-1:0] chk_rs1,
  input  logic [REG_WIDTH-1:0] chk_rs2,
  input  logic [REG_WIDTH-1:0] chk_rd,
  output logic                 hazard
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;
  logic                rs1_hit;
  logic                rs2_hit;
  logic                waw_hit;

  // Set is applied after clear so a new producer wins over the retiring write.
  always_comb begin
    busy_nxt = busy;
    if (reg_we) busy_nxt[rd_addr] = 1'b0;
    if (issue_valid) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  assign rs1_hit = busy[chk_rs1] && (chk_rs1 != '0) && !(reg_we && (rd_addr == chk_rs1));
  assign rs2_hit = busy[chk_rs2] && (chk_rs2 != '0) && !(reg_we && (rd_addr == chk_rs2));
  // The destination check is never bypassed: one in-flight writer per register.
  assign waw_hit = busy[chk_rd] && (chk_rd != '0);
  assign hazard  = rs1_hit || rs2_hit || waw_hit;

  issue_while_hazard: assert property (@(posedge clock) disable iff (!reset)
    issue_valid |-> !hazard);

endmodule

// File: rtl/ysyx_24080006_wb.sv
// Writeback stage: fixed-priority LSU > MDU > ALU arbiter into one registered
// write port, plus scoreboard. Perf counters built only with YSYX_24080006_WB_PERF_EN.
module ysyx_24080006_wb
  import ysyx_24080006_pkg::*;
#(
  parameter int PERF_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [REG_WIDTH-1:0]  lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  input  logic                  mdu_valid,
  output logic                  mdu_ready,
  input  logic [REG_WIDTH-1:0]  mdu_rd,
  input  logic [DATA_WIDTH-1:0] mdu_data,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_WIDTH-1:0]  alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  issue_valid,
  input  logic [REG_WIDTH-1:0]  issue_rd,
  input  logic [REG_WIDTH-1:0]  chk_rs1,
  input  logic [REG_WIDTH-1:0]  chk_rs2,
  input  logic [REG_WIDTH-1:0]  chk_rd,
  output logic                  hazard,
  output logic                  reg_we,
  output logic [REG_WIDTH-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [PERF_WIDTH-1:0] perf_conflict,
  output logic [PERF_WIDTH-1:0] perf_stall
);

  wb_req_t lsu_req;
  wb_req_t mdu_req;
  wb_req_t alu_req;
  wb_req_t win;
  wb_src_e sel;

  assign lsu_req = {lsu_valid, lsu_rd, lsu_data};
  assign mdu_req = {mdu_valid, mdu_rd, mdu_data};
  assign alu_req = {alu_valid, alu_rd, alu_data};

  always_comb begin
    sel = WB_NONE;
    win = '0;
    if (lsu_req.valid) begin
      sel = WB_LSU;
      win = lsu_req;
    end else if (mdu_req.valid) begin
      sel = WB_MDU;
      win = mdu_req;
    end else if (alu_req.valid) begin
      sel = WB_ALU;
      win = alu_req;
    end
  end

  // Idle and reset both advertise ready so sources never see a stuck handshake.
  assign lsu_ready = !reset || (sel == WB_NONE) || (sel == WB_LSU);
  assign mdu_ready = !reset || (sel == WB_NONE) || (sel == WB_MDU);
  assign alu_ready = !reset || (sel == WB_NONE) || (sel == WB_ALU);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      reg_we  <= 1'b0;
      rd_addr <= '0;
      rd_data <= '0;
    end else begin
      reg_we <= win.valid && (win.rd != '0);
      if (win.valid) begin
        rd_addr <= win.rd;
        rd_data <= win.data;
      end
    end
  end

  ysyx_24080006_scoreboard u_scoreboard (
    .clock       (clock),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .reg_we      (reg_we),
    .rd_addr     (rd_addr),
    .chk_rs1     (chk_rs1),
    .chk_rs2     (chk_rs2),
    .chk_rd      (chk_rd),
    .hazard      (hazard)
  );

`ifdef YSYX_24080006_WB_PERF_EN
  logic [PERF_WIDTH-1:0] conflict_q;
  logic [PERF_WIDTH-1:0] stall_q;
  logic                  multi_valid;

  assign multi_valid = (lsu_valid && mdu_valid) || (lsu_valid && alu_valid) ||
                       (mdu_valid && alu_valid);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      conflict_q <= '0;
      stall_q    <= '0;
    end else begin
      if (multi_valid) conflict_q <= conflict_q + PERF_WIDTH'(1);
      if (hazard) stall_q <= stall_q + PERF_WIDTH'(1);
    end
  end

  assign perf_conflict = conflict_q;
  assign perf_stall    = stall_q;
`else
  assign perf_conflict = {PERF_WIDTH{1'b0}};
  assign perf_stall    = {PERF_WIDTH{1'b0}};
`endif

endmodule
